// File: rtl/reg_file.sv
// SID-compatible register bank behind the SPI slave.
// Holds voice, filter and volume registers, emits per-voice gate-edge pulses
// and multiplexes the oscillator-3 / envelope-3 values onto the read path.
module reg_file #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_W-1:0]         reg_addr_i,
    input  logic [7:0]                reg_wdata_i,
    input  logic                      reg_we_i,
    output logic [7:0]                reg_rdata_o,
    input  logic [7:0]                osc3_i,
    input  logic [7:0]                env3_i,
    output logic [16*NUM_VOICES-1:0]  voice_freq_o,
    output logic [12*NUM_VOICES-1:0]  voice_pw_o,
    output logic [8*NUM_VOICES-1:0]   voice_ctrl_o,
    output logic [8*NUM_VOICES-1:0]   voice_ad_o,
    output logic [8*NUM_VOICES-1:0]   voice_sr_o,
    output logic [10:0]               filt_fc_o,
    output logic [7:0]                filt_res_o,
    output logic [7:0]                mode_vol_o,
    output logic [NUM_VOICES-1:0]     gate_rise_o,
    output logic [NUM_VOICES-1:0]     gate_fall_o
);

    localparam logic [ADDR_W-1:0] ADDR_FC_LO    = ADDR_W'(8'h15);
    localparam logic [ADDR_W-1:0] ADDR_FC_HI    = ADDR_W'(8'h16);
    localparam logic [ADDR_W-1:0] ADDR_RES_FILT = ADDR_W'(8'h17);
    localparam logic [ADDR_W-1:0] ADDR_MODE_VOL = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] ADDR_OSC3     = ADDR_W'(8'h1B);
    localparam logic [ADDR_W-1:0] ADDR_ENV3     = ADDR_W'(8'h1C);

    logic              we_q;
    logic              wr_pend_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              we_rise;

    logic [7:0] freq_lo_q [NUM_VOICES];
    logic [7:0] freq_hi_q [NUM_VOICES];
    logic [7:0] pw_lo_q   [NUM_VOICES];
    logic [3:0] pw_hi_q   [NUM_VOICES];
    logic [7:0] ctrl_q    [NUM_VOICES];
    logic [7:0] ad_q      [NUM_VOICES];
    logic [7:0] sr_q      [NUM_VOICES];
    logic [2:0] fc_lo_q;
    logic [7:0] fc_hi_q;
    logic [7:0] res_q;
    logic [7:0] mode_vol_q;
    logic [NUM_VOICES-1:0] gate_rise_q;
    logic [NUM_VOICES-1:0] gate_fall_q;
    logic [7:0] rdata_d;
    logic [7:0] rdata_q;

    assign we_rise = reg_we_i & ~we_q;

    // Detect the strobe's rising edge and latch the address/data to commit.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge values of the others.
        if (rst_i) begin
            // NOTE: we_q follows the strobe even in reset, so a strobe held
            // across reset release is not mistaken for a fresh edge.
            we_q      <= reg_we_i;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            we_q      <= reg_we_i;
            wr_pend_q <= we_rise;
            if (we_rise) begin
                wr_addr_q <= reg_addr_i;
                wr_data_q <= reg_wdata_i;
            end
        end
    end

    // Commit the pending write into the register bank and flag gate edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the register arrays are small and drive live datapaths,
            // so every entry is explicitly cleared rather than left unknown.
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_lo_q[v] <= '0;
                freq_hi_q[v] <= '0;
                pw_lo_q[v]   <= '0;
                pw_hi_q[v]   <= '0;
                ctrl_q[v]    <= '0;
                ad_q[v]      <= '0;
                sr_q[v]      <= '0;
            end
            fc_lo_q     <= '0;
            fc_hi_q     <= '0;
            res_q       <= '0;
            mode_vol_q  <= '0;
            gate_rise_q <= '0;
            gate_fall_q <= '0;
        end else begin
            gate_rise_q <= '0;
            gate_fall_q <= '0;
            if (wr_pend_q) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (wr_addr_q == ADDR_W'(7 * v + 0)) freq_lo_q[v] <= wr_data_q;
                    if (wr_addr_q == ADDR_W'(7 * v + 1)) freq_hi_q[v] <= wr_data_q;
                    if (wr_addr_q == ADDR_W'(7 * v + 2)) pw_lo_q[v]   <= wr_data_q;
                    if (wr_addr_q == ADDR_W'(7 * v + 3)) pw_hi_q[v]   <= wr_data_q[3:0];
                    if (wr_addr_q == ADDR_W'(7 * v + 4)) begin
                        ctrl_q[v]      <= wr_data_q;
                        gate_rise_q[v] <= wr_data_q[0] & ~ctrl_q[v][0];
                        gate_fall_q[v] <= ~wr_data_q[0] & ctrl_q[v][0];
                    end
                    if (wr_addr_q == ADDR_W'(7 * v + 5)) ad_q[v]      <= wr_data_q;
                    if (wr_addr_q == ADDR_W'(7 * v + 6)) sr_q[v]      <= wr_data_q;
                end
                case (wr_addr_q)
                    ADDR_FC_LO:    fc_lo_q    <= wr_data_q[2:0];
                    ADDR_FC_HI:    fc_hi_q    <= wr_data_q;
                    ADDR_RES_FILT: res_q      <= wr_data_q;
                    ADDR_MODE_VOL: mode_vol_q <= wr_data_q;
                    default:       ;
                endcase
            end
        end
    end

    // Select the read value for the currently presented address.
    always_comb begin
        // NOTE: default first so no path through the decode infers a latch.
        rdata_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (reg_addr_i == ADDR_W'(7 * v + 0)) rdata_d = freq_lo_q[v];
            if (reg_addr_i == ADDR_W'(7 * v + 1)) rdata_d = freq_hi_q[v];
            if (reg_addr_i == ADDR_W'(7 * v + 2)) rdata_d = pw_lo_q[v];
            if (reg_addr_i == ADDR_W'(7 * v + 3)) rdata_d = {4'b0000, pw_hi_q[v]};
            if (reg_addr_i == ADDR_W'(7 * v + 4)) rdata_d = ctrl_q[v];
            if (reg_addr_i == ADDR_W'(7 * v + 5)) rdata_d = ad_q[v];
            if (reg_addr_i == ADDR_W'(7 * v + 6)) rdata_d = sr_q[v];
        end
        case (reg_addr_i)
            ADDR_FC_LO:    rdata_d = {5'b00000, fc_lo_q};
            ADDR_FC_HI:    rdata_d = fc_hi_q;
            ADDR_RES_FILT: rdata_d = res_q;
            ADDR_MODE_VOL: rdata_d = mode_vol_q;
            ADDR_OSC3:     rdata_d = osc3_i;
            ADDR_ENV3:     rdata_d = env3_i;
            default:       ;
        endcase
    end

    // Register the read data toward the SPI slave.
    always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice_out
        assign voice_freq_o[16*v +: 16] = {freq_hi_q[v], freq_lo_q[v]};
        assign voice_pw_o[12*v +: 12]   = {pw_hi_q[v], pw_lo_q[v]};
        assign voice_ctrl_o[8*v +: 8]   = ctrl_q[v];
        assign voice_ad_o[8*v +: 8]     = ad_q[v];
        assign voice_sr_o[8*v +: 8]     = sr_q[v];
    end

    assign filt_fc_o   = {fc_hi_q, fc_lo_q};
    assign filt_res_o  = res_q;
    assign mode_vol_o  = mode_vol_q;
    assign gate_rise_o = gate_rise_q;
    assign gate_fall_o = gate_fall_q;
    assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: an address-indexed register model
// predicts every output each cycle, and directed vectors pin the model.
module tb_reg_file;

    localparam int NV = 3;
    localparam int AW = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic [7:0]        wdata = '0;
    logic              we = 1'b0;
    logic [7:0]        osc3 = '0;
    logic [7:0]        env3 = '0;
    logic [7:0]        rdata;
    logic [16*NV-1:0]  freq;
    logic [12*NV-1:0]  pw;
    logic [8*NV-1:0]   ctrl, ad, sr;
    logic [10:0]       fc;
    logic [7:0]        res, mode_vol;
    logic [NV-1:0]     rise, fall;

    reg_file #(.NUM_VOICES(NV), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_we_i(we), .reg_rdata_o(rdata), .osc3_i(osc3), .env3_i(env3),
        .voice_freq_o(freq), .voice_pw_o(pw), .voice_ctrl_o(ctrl),
        .voice_ad_o(ad), .voice_sr_o(sr), .filt_fc_o(fc), .filt_res_o(res),
        .mode_vol_o(mode_vol), .gate_rise_o(rise), .gate_fall_o(fall)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]    mem [128];
    bit            valid = 0;
    bit            prev_we = 0;
    bit            pend = 0;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_data;
    logic [7:0]    exp_rdata = '0;
    logic [NV-1:0] exp_rise = '0, exp_fall = '0;

    function automatic logic [7:0] model_read(input int a, input logic [7:0] o3, input logic [7:0] e3);
        if (a == 'h1B) return o3;
        if (a == 'h1C) return e3;
        if (a <= 'h18) return mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            valid = 1;
            foreach (mem[i]) mem[i] = 8'h00;
            exp_rdata = '0;
            exp_rise = '0;
            exp_fall = '0;
            pend = 0;
        end else begin
            int a;
            exp_rdata = model_read(int'(addr), osc3, env3);
            exp_rise = '0;
            exp_fall = '0;
            if (pend) begin
                a = int'(pend_addr);
                if (a < 7 * NV && a % 7 == 4) begin
                    exp_rise[a/7] = pend_data[0] & ~mem[a][0];
                    exp_fall[a/7] = ~pend_data[0] & mem[a][0];
                end
                if (a < 7 * NV && a % 7 == 3) mem[a] = pend_data & 8'h0F;
                else if (a == 'h15)           mem[a] = pend_data & 8'h07;
                else if (a <= 'h18)           mem[a] = pend_data;
            end
            pend = we && !prev_we;
            pend_addr = addr;
            pend_data = wdata;
        end
        prev_we = we;
    end

    // ---------------- per-cycle compare ----------------
    int rise_cnt [NV];
    int fall_cnt [NV];
    initial foreach (rise_cnt[i]) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end

    always @(negedge clk) begin
        if (valid) begin
            logic [16*NV-1:0] ef;
            logic [12*NV-1:0] ep;
            logic [8*NV-1:0]  ec, ea, es;
            for (int v = 0; v < NV; v++) begin
                ef[16*v +: 16] = {mem[7*v+1], mem[7*v]};
                ep[12*v +: 12] = {mem[7*v+3][3:0], mem[7*v+2]};
                ec[8*v +: 8]   = mem[7*v+4];
                ea[8*v +: 8]   = mem[7*v+5];
                es[8*v +: 8]   = mem[7*v+6];
            end
            check("rdata", 64'(rdata), 64'(exp_rdata));
            check("freq", 64'(freq), 64'(ef));
            check("pw", 64'(pw), 64'(ep));
            check("ctrl", 64'(ctrl), 64'(ec));
            check("ad", 64'(ad), 64'(ea));
            check("sr", 64'(sr), 64'(es));
            check("fc", 64'(fc), 64'({mem['h16], mem['h15][2:0]}));
            check("res", 64'(res), 64'(mem['h17]));
            check("mode_vol", 64'(mode_vol), 64'(mem['h18]));
            check("gate_rise", 64'(rise), 64'(exp_rise));
            check("gate_fall", 64'(fall), 64'(exp_fall));
            for (int v = 0; v < NV; v++) begin
                if (rise[v]) rise_cnt[v]++;
                if (fall[v]) fall_cnt[v]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
        @(posedge clk); #1;
        addr = a;
        @(posedge clk);
        @(negedge clk);
        check(name, 64'(rdata), 64'(exp));
    endtask

    initial begin
        int r0, r1, f1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: whole mapped range reads zero, outputs idle.
        for (int a = 0; a <= 'h1C; a++) rd(AW'(a), 8'h00, "reset_read");
        check("reset_freq", 64'(freq), 64'd0);
        check("reset_gates", 64'({rise, fall}), 64'd0);

        // Voice-2 frequency and pulse width.
        wr(7'h0E, 8'h34);
        wr(7'h0F, 8'h12);
        check("v2_freq", 64'(freq[47:32]), 64'h1234);
        wr(7'h10, 8'hFF);
        wr(7'h11, 8'hFF);
        check("v2_pw", 64'(pw[35:24]), 64'hFFF);
        rd(7'h11, 8'h0F, "v2_pw_hi_read");
        rd(7'h0E, 8'h34, "v2_freq_lo_read");

        // Long strobe: one commit, one single-cycle gate rise on voice 0.
        r0 = rise_cnt[0];
        @(posedge clk); #1;
        addr = 7'h04; wdata = 8'h41; we = 1'b1;
        repeat (10) @(posedge clk);
        #1 we = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("long_strobe_rise_cycles", 64'(rise_cnt[0] - r0), 64'd1);
        check("long_strobe_ctrl0", 64'(ctrl[7:0]), 64'h41);

        // Voice-1 gate edges.
        r1 = rise_cnt[1]; f1 = fall_cnt[1];
        wr(7'h0B, 8'h41);
        wr(7'h0B, 8'h41);
        check("v1_rise_once", 64'(rise_cnt[1] - r1), 64'd1);
        check("v1_no_fall_yet", 64'(fall_cnt[1] - f1), 64'd0);
        wr(7'h0B, 8'h40);
        check("v1_fall_once", 64'(fall_cnt[1] - f1), 64'd1);
        check("v1_ctrl", 64'(ctrl[15:8]), 64'h40);

        // Filter registers and masked FC_LO readback.
        wr(7'h15, 8'hFD);
        wr(7'h16, 8'hAB);
        check("fc", 64'(fc), 64'h55D);
        rd(7'h15, 8'h05, "fc_lo_read");

        // Read-only and unmapped addresses.
        osc3 = 8'hA5; env3 = 8'h3C;
        rd(7'h1B, 8'hA5, "osc3_read");
        rd(7'h1C, 8'h3C, "env3_read");
        wr(7'h1B, 8'hFF);
        wr(7'h50, 8'hFF);
        rd(7'h50, 8'h00, "unmapped_read");
        rd(7'h1B, 8'hA5, "osc3_after_write");
        check("ro_write_no_change", 64'(freq[47:32]), 64'h1234);

        // Reset asserted in the commit cycle of a MODE_VOL write.
        @(posedge clk); #1;
        addr = 7'h18; wdata = 8'h0F; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wins_mode_vol", 64'(mode_vol), 64'h00);
        check("reset_cleared_freq", 64'(freq[47:32]), 64'h0000);

        // Strobe already high when reset releases: no write.
        rst = 1'b1; addr = 7'h18; wdata = 8'h0F; we = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_we_no_write", 64'(mode_vol), 64'h00);

        // A fresh write afterwards still works with correct read-after-write.
        wr(7'h18, 8'h0F);
        check("mode_vol_write", 64'(mode_vol), 64'h0F);
        rd(7'h18, 8'h0F, "mode_vol_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
